tmu2_qpram_sched: RTL and testbench

TMU2_QPRAM_SCHED -- requirements
Module: tmu2_qpram_sched

---
 rtl/tmu2_qpram_sched_if.sv | 71 +++++++
 rtl/tmu2_qpram_sched.sv | 142 ++++++++++++++
 tb/tb_tmu2_qpram_sched.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tmu2_qpram_sched_if.sv
// rtl/tmu2_qpram_sched_if.sv - bus bundle between the texel scheduler, its requesters and the quad-port RAM
//
// Groups every non-clock signal of tmu2_qpram_sched.
//   read request  : rd_stb_i, rd_ack_o, rd_a_i..rd_d_i (byte addresses, 16-bit aligned)
//   texel output  : rd_stb_o, rd_ack_i, rd_a_o..rd_d_o (16-bit texels)
//   line fill     : fill_stb_i, fill_ack_o, fill_adr_i (256-bit aligned), fill_dat_i
//   RAM side      : q_raa..q_rad, q_rda..q_rdd, q_we, q_wa, q_wd
//   status        : busy
// slave is the scheduler's view; master is the view of everything around it.
interface tmu2_qpram_sched_if #(
  parameter int depth = 11
);
  logic             rd_stb_i;
  logic             rd_ack_o;
  logic [depth-1:0] rd_a_i;
  logic [depth-1:0] rd_b_i;
  logic [depth-1:0] rd_c_i;
  logic [depth-1:0] rd_d_i;

  logic             rd_stb_o;
  logic             rd_ack_i;
  logic [15:0]      rd_a_o;
  logic [15:0]      rd_b_o;
  logic [15:0]      rd_c_o;
  logic [15:0]      rd_d_o;

  logic             fill_stb_i;
  logic             fill_ack_o;
  logic [depth-1:0] fill_adr_i;
  logic [255:0]     fill_dat_i;

  logic [depth-1:0] q_raa;
  logic [depth-1:0] q_rab;
  logic [depth-1:0] q_rac;
  logic [depth-1:0] q_rad;
  logic [15:0]      q_rda;
  logic [15:0]      q_rdb;
  logic [15:0]      q_rdc;
  logic [15:0]      q_rdd;
  logic             q_we;
  logic [depth-1:0] q_wa;
  logic [255:0]     q_wd;

  logic             busy;

  modport slave (
    input  rd_stb_i, rd_a_i, rd_b_i, rd_c_i, rd_d_i,
    output rd_ack_o,
    output rd_stb_o, rd_a_o, rd_b_o, rd_c_o, rd_d_o,
    input  rd_ack_i,
    input  fill_stb_i, fill_adr_i, fill_dat_i,
    output fill_ack_o,
    output q_raa, q_rab, q_rac, q_rad,
    input  q_rda, q_rdb, q_rdc, q_rdd,
    output q_we, q_wa, q_wd,
    output busy
  );

  modport master (
    output rd_stb_i, rd_a_i, rd_b_i, rd_c_i, rd_d_i,
    input  rd_ack_o,
    input  rd_stb_o, rd_a_o, rd_b_o, rd_c_o, rd_d_o,
    output rd_ack_i,
    output fill_stb_i, fill_adr_i, fill_dat_i,
    input  fill_ack_o,
    input  q_raa, q_rab, q_rac, q_rad,
    output q_rda, q_rdb, q_rdc, q_rdd,
    input  q_we, q_wa, q_wd,
    input  busy
  );
endinterface

// File: rtl/tmu2_qpram_sched.sv
// rtl/tmu2_qpram_sched.sv - read/fill scheduler in front of the texel quad-port RAM
//
// Ports:
//   sys_clk    : sole clock, rising edge
//   sys_rst_n  : asynchronous active-low reset
//   bus        : tmu2_qpram_sched_if.slave (read requests, texel output, line fills, RAM port, busy)
//
// One RAM address path is shared, so each cycle grants either a texel quad read or a
// line fill. Read data comes back from the RAM one cycle after the grant and lands in a
// 2-entry output FIFO. A read is only issued when the FIFO is guaranteed room for it, so
// downstream back-pressure never loses data. fill_run bounds how long fills may starve a
// pending read that could be issued.
module tmu2_qpram_sched #(
  parameter int depth    = 11,
  parameter int fill_max = 4
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  tmu2_qpram_sched_if.slave  bus
);

  localparam logic [3:0] FILL_MAX = 4'(fill_max);

  // Low from reset until the first clock edge after release; gates every grant so no
  // acknowledge or RAM write can escape while the block is (or was just) in reset.
  logic             active_q;

  logic             inflight_q;
  logic [63:0]      fifo_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic [3:0]       fill_run_q;
  logic [3:0]       fill_run_d;

  logic             rd_gnt;
  logic             fill_gnt;
  logic             push;
  logic             pop;
  logic             stb_w;
  logic             issuable;
  logic [1:0]       credit;
  logic [63:0]      head;
  logic [depth-1:0] wa_w;

  assign stb_w = (count_q != 2'd0);
  assign pop   = stb_w & bus.rd_ack_i;
  assign push  = inflight_q;

  // Credit counts every quad that will occupy the FIFO: the one in the RAM pipeline plus
  // the buffered ones. A quad popped this cycle frees its slot before a new grant lands.
  assign credit   = {1'b0, inflight_q} + count_q;
  assign issuable = (credit - {1'b0, pop}) < 2'd2;

  always_comb begin
    rd_gnt   = 1'b0;
    fill_gnt = 1'b0;
    if (active_q) begin
      if (bus.fill_stb_i && bus.rd_stb_i) begin
        if (fill_run_q == FILL_MAX && issuable) begin
          rd_gnt = 1'b1;
        end else begin
          fill_gnt = 1'b1;
        end
      end else if (bus.fill_stb_i) begin
        fill_gnt = 1'b1;
      end else if (bus.rd_stb_i && issuable) begin
        rd_gnt = 1'b1;
      end
    end
  end

  // Counts fills that overtook a waiting read; saturates so a read that cannot issue
  // keeps priority ready for the moment it becomes issuable.
  always_comb begin
    fill_run_d = fill_run_q;
    if (!bus.rd_stb_i || rd_gnt) begin
      fill_run_d = 4'd0;
    end else if (fill_gnt && fill_run_q < FILL_MAX) begin
      fill_run_d = fill_run_q + 4'd1;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      active_q   <= 1'b0;
      inflight_q <= 1'b0;
      fill_run_q <= 4'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      fifo_q[0]  <= 64'd0;
      fifo_q[1]  <= 64'd0;
    end else begin
      active_q   <= 1'b1;
      inflight_q <= rd_gnt;
      fill_run_q <= fill_run_d;
      count_q    <= count_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= {bus.q_rda, bus.q_rdb, bus.q_rdc, bus.q_rdd};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  assign head = fifo_q[rd_ptr_q];

  assign bus.rd_ack_o   = bus.rd_stb_i & rd_gnt;
  assign bus.fill_ack_o = bus.fill_stb_i & fill_gnt;

  assign bus.rd_stb_o = stb_w;
  assign bus.rd_a_o   = head[63:48];
  assign bus.rd_b_o   = head[47:32];
  assign bus.rd_c_o   = head[31:16];
  assign bus.rd_d_o   = head[15:0];

  assign bus.q_raa = bus.rd_a_i;
  assign bus.q_rab = bus.rd_b_i;
  assign bus.q_rac = bus.rd_c_i;
  assign bus.q_rad = bus.rd_d_i;

  assign wa_w     = bus.fill_adr_i;
  assign bus.q_we = fill_gnt;
  assign bus.q_wa = wa_w;
  assign bus.q_wd = bus.fill_dat_i;

  assign bus.busy = inflight_q | stb_w;

endmodule

// File: tb/tb_tmu2_qpram_sched.sv
// tb/tb_tmu2_qpram_sched.sv - self-checking bench for tmu2_qpram_sched
module tb_tmu2_qpram_sched;

  localparam int DEPTH    = 11;
  localparam int FILL_MAX = 4;
  localparam logic [255:0] P = 256'h1111_BEEF_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_F00D;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  tmu2_qpram_sched_if #(.depth(DEPTH)) bus ();

  tmu2_qpram_sched #(.depth(DEPTH), .fill_max(FILL_MAX)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Big-endian byte order inside a line: byte offset 0 is the top byte.
  function automatic logic [15:0] word_of(input logic [255:0] line, input logic [4:0] off);
    logic [255:0] t;
    t = line << (8 * off);
    return t[255:240];
  endfunction

  function automatic logic [255:0] init_line(input int i);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = 32'(i) * 32'h9E37_79B1 + 32'(k) * 32'h1111_1111;
    return l;
  endfunction

  // RAM environment: synchronous read, one cycle latency.
  logic [255:0] ram  [64];
  logic [255:0] mmem [64];

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram[i]  = init_line(i);
      mmem[i] = init_line(i);
    end
  end

  always @(posedge clk) begin
    if (bus.q_we) ram[bus.q_wa[DEPTH-1:5]] <= bus.q_wd;
    bus.q_rda <= word_of(ram[bus.q_raa[DEPTH-1:5]], bus.q_raa[4:0]);
    bus.q_rdb <= word_of(ram[bus.q_rab[DEPTH-1:5]], bus.q_rab[4:0]);
    bus.q_rdc <= word_of(ram[bus.q_rac[DEPTH-1:5]], bus.q_rac[4:0]);
    bus.q_rdd <= word_of(ram[bus.q_rad[DEPTH-1:5]], bus.q_rad[4:0]);
  end

  function automatic logic [63:0] model_quad(input logic [DEPTH-1:0] a, b, c, d);
    return {word_of(mmem[a[DEPTH-1:5]], a[4:0]), word_of(mmem[b[DEPTH-1:5]], b[4:0]),
            word_of(mmem[c[DEPTH-1:5]], c[4:0]), word_of(mmem[d[DEPTH-1:5]], d[4:0])};
  endfunction

  // Model: one queue of every granted-but-not-delivered quad, each stamped with the first
  // cycle it may be shown. Its length is the credit; its visible head is the output.
  typedef struct {
    logic [63:0] data;
    int          vis;
  } quad_t;

  quad_t m_q[$];
  int    m_cyc    = 0;
  int    m_run    = 0;
  bit    m_active = 0;

  always @(negedge clk) begin
    bit stb_e, pop_e, iss, rg, fg;
    if (!rst_n) begin
      chk("rst_rd_stb_o", bus.rd_stb_o, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_rd_ack_o", bus.rd_ack_o, 1'b0);
      chk("rst_fill_ack_o", bus.fill_ack_o, 1'b0);
      chk("rst_q_we", bus.q_we, 1'b0);
      chk("rst_rd_out", {bus.rd_a_o, bus.rd_b_o, bus.rd_c_o, bus.rd_d_o}, 64'd0);
      m_q.delete();
      m_run    = 0;
      m_active = 0;
    end else begin
      stb_e = (m_q.size() > 0) && (m_q[0].vis <= m_cyc);
      pop_e = stb_e && bus.rd_ack_i;
      iss   = (m_q.size() - int'(pop_e)) < 2;
      rg = 0;
      fg = 0;
      if (m_active) begin
        if (bus.fill_stb_i && bus.rd_stb_i) begin
          if (m_run == FILL_MAX && iss) rg = 1; else fg = 1;
        end else if (bus.fill_stb_i) fg = 1;
        else if (bus.rd_stb_i && iss) rg = 1;
      end
      chk("rd_ack_o", bus.rd_ack_o, rg);
      chk("fill_ack_o", bus.fill_ack_o, fg);
      chk("q_we", bus.q_we, fg);
      if (fg) begin
        chk("q_wa", bus.q_wa, bus.fill_adr_i);
        chk("q_wd", bus.q_wd, bus.fill_dat_i);
      end
      chk("q_raddr", {bus.q_raa, bus.q_rab, bus.q_rac, bus.q_rad},
          {bus.rd_a_i, bus.rd_b_i, bus.rd_c_i, bus.rd_d_i});
      chk("rd_stb_o", bus.rd_stb_o, stb_e);
      chk("busy", bus.busy, m_q.size() > 0);
      if (stb_e) chk("rd_quad", {bus.rd_a_o, bus.rd_b_o, bus.rd_c_o, bus.rd_d_o}, m_q[0].data);
      if (pop_e) void'(m_q.pop_front());
      if (rg) m_q.push_back('{data: model_quad(bus.rd_a_i, bus.rd_b_i, bus.rd_c_i, bus.rd_d_i), vis: m_cyc + 2});
      if (fg) mmem[bus.fill_adr_i[DEPTH-1:5]] = bus.fill_dat_i;
      if (!bus.rd_stb_i || rg) m_run = 0;
      else if (fg && m_run < FILL_MAX) m_run++;
      m_active = 1;
    end
    m_cyc++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic stb, input logic [DEPTH-1:0] a, b, c, d);
    bus.rd_stb_i = stb;
    bus.rd_a_i   = a;
    bus.rd_b_i   = b;
    bus.rd_c_i   = c;
    bus.rd_d_i   = d;
  endtask

  initial begin
    logic [9:0] fpat, rpat;
    int nr, nf, np, first, last;

    set_rd(1'b0, '0, '0, '0, '0);
    bus.rd_ack_i   = 1'b1;
    bus.fill_stb_i = 1'b0;
    bus.fill_adr_i = '0;
    bus.fill_dat_i = '0;

    #2 rst_n = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    chk("reset_stb", bus.rd_stb_o, 1'b0);
    chk("reset_busy", bus.busy, 1'b0);
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();

    // Fill line 0x020 with P, read from it the very next cycle.
    bus.fill_stb_i = 1'b1;
    bus.fill_adr_i = 11'h020;
    bus.fill_dat_i = P;
    @(negedge clk);
    chk("a_fill_ack", bus.fill_ack_o, 1'b1);
    cyc();
    bus.fill_stb_i = 1'b0;
    set_rd(1'b1, 11'h022, 11'h020, 11'h03e, 11'h024);
    @(negedge clk);
    chk("a_rd_ack", bus.rd_ack_o, 1'b1);
    cyc();
    set_rd(1'b0, '0, '0, '0, '0);
    @(negedge clk);
    chk("a_stb_early", bus.rd_stb_o, 1'b0);
    cyc();
    @(negedge clk);
    chk("a_stb_on_time", bus.rd_stb_o, 1'b1);
    chk("a_rd_a", bus.rd_a_o, 16'hBEEF);
    chk("a_rd_b", bus.rd_b_o, 16'h1111);
    chk("a_rd_c", bus.rd_c_o, 16'hF00D);
    chk("a_rd_d", bus.rd_d_o, 16'h2222);
    repeat (3) cyc();

    // Fill and read both held: four fills then one read, repeating.
    bus.fill_stb_i = 1'b1;
    set_rd(1'b1, 11'h0a2, 11'h0c4, 11'h1e6, 11'h708);
    for (int i = 0; i < 10; i++) begin
      bus.fill_adr_i = 11'(32 * (8 + i));
      bus.fill_dat_i = {8{32'(i) ^ 32'hA5A5_0000}};
      @(negedge clk);
      fpat[9-i] = bus.fill_ack_o;
      rpat[9-i] = bus.rd_ack_o;
      cyc();
    end
    chk("b_fill_pattern", fpat, 10'b1111011110);
    chk("b_read_pattern", rpat, 10'b0000100001);
    bus.fill_stb_i = 1'b0;
    set_rd(1'b0, '0, '0, '0, '0);
    repeat (4) cyc();

    // Eight back-to-back reads, output always accepted.
    np = 0; nr = 0; first = -1; last = -1;
    for (int i = 0; i < 14; i++) begin
      if (i < 8) set_rd(1'b1, 11'(12'h040 + 2 * i), 11'(12'h020 + 2 * i), 11'(12'h300 + 6 * i), 11'(12'h7e0 + 2 * i));
      else set_rd(1'b0, '0, '0, '0, '0);
      @(negedge clk);
      if (bus.rd_ack_o) nr++;
      if (bus.rd_stb_o && bus.rd_ack_i) begin
        np++;
        if (first < 0) first = i;
        last = i;
      end
      cyc();
    end
    chk("c_grants", nr, 8);
    chk("c_pops", np, 8);
    chk("c_consecutive", last - first, 7);
    chk("c_first_latency", first, 2);

    // Output stalled: only two reads fit, fills keep flowing.
    bus.rd_ack_i   = 1'b0;
    bus.fill_stb_i = 1'b1;
    set_rd(1'b1, 11'h100, 11'h102, 11'h104, 11'h106);
    nr = 0; nf = 0;
    for (int i = 0; i < 20; i++) begin
      bus.fill_adr_i = 11'(32 * (20 + (i % 4)));
      bus.fill_dat_i = {16{16'(i) + 16'h3C00}};
      @(negedge clk);
      if (bus.rd_ack_o) nr++;
      if (bus.fill_ack_o) nf++;
      cyc();
    end
    chk("d_reads_accepted", nr, 2);
    chk("d_fills_granted", nf, 18);
    bus.fill_stb_i = 1'b0;
    set_rd(1'b0, '0, '0, '0, '0);
    bus.rd_ack_i = 1'b1;
    np = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.rd_stb_o && bus.rd_ack_i) np++;
      cyc();
    end
    chk("d_drained", np, 2);

    // Full FIFO, then pop and new grant in the same cycle.
    bus.rd_ack_i = 1'b0;
    set_rd(1'b1, 11'h280, 11'h28e, 11'h6a0, 11'h01e);
    repeat (4) cyc();
    bus.rd_ack_i = 1'b1;
    set_rd(1'b1, 11'h2a0, 11'h2ae, 11'h6c0, 11'h03e);
    @(negedge clk);
    chk("e_pop", bus.rd_stb_o, 1'b1);
    chk("e_grant_with_pop", bus.rd_ack_o, 1'b1);
    cyc();
    set_rd(1'b1, 11'h4a4, 11'h4a6, 11'h4a8, 11'h4aa);
    cyc();
    set_rd(1'b0, '0, '0, '0, '0);
    repeat (5) cyc();
    @(negedge clk);
    chk("e_empty", bus.busy, 1'b0);

    // Reset with a read in flight.
    set_rd(1'b1, 11'h5f0, 11'h5f2, 11'h5f4, 11'h5f6);
    cyc();
    set_rd(1'b0, '0, '0, '0, '0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("f_rst_stb", bus.rd_stb_o, 1'b0);
    chk("f_rst_busy", bus.busy, 1'b0);
    cyc();
    rst_n = 1'b1;
    np = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.rd_stb_o || bus.busy) np++;
      cyc();
    end
    chk("f_no_spurious", np, 0);

    // Normal operation resumes after reset.
    set_rd(1'b1, 11'h022, 11'h100, 11'h3fe, 11'h7fe);
    cyc();
    set_rd(1'b0, '0, '0, '0, '0);
    cyc();
    @(negedge clk);
    chk("g_resume_stb", bus.rd_stb_o, 1'b1);
    chk("g_resume_a", bus.rd_a_o, 16'hBEEF);
    repeat (3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
